qed_dup_scheduler: RTL and testbench
====================================

QED_DUP_SCHEDULER -- requirements
Module: qed_dup_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning duplicate-queue depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 4, meaning occupancy counter width (log2(DEPTH)+1).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-low reset.
REQ-005 SHALL have port instruction  input  32  meaning original instruction from the fetch source.
REQ-006 SHALL have port inst_valid  input  1  meaning instruction is valid this cycle.
REQ-007 SHALL have port inst_ready  output  1  meaning the scheduler accepts instruction this cycle (combinational).
REQ-008 SHALL have port qed_exec_dup  input  1  meaning request to switch to issuing duplicates.
REQ-009 SHALL have port pipeline_stall  input  1  meaning the hazard unit is stalling IF/ID.
REQ-010 SHALL have port qed_ifu_instruction  output  32  meaning instruction issued to IF/ID (registered).
REQ-011 SHALL have port qed_vld_out  output  1  meaning qed_ifu_instruction is a new valid issue (registered).
REQ-012 SHALL have port qed_is_dup  output  1  meaning the current issue is a duplicate (registered).
REQ-013 SHALL have port dup_count  output  CNT_W  meaning number of queued, not-yet-issued duplicates.
REQ-014 SHALL have port qed_ready  output  1  meaning dup_count==0 (every issued original has its duplicate issued).

Function
REQ-015 SHALL implement FSM states ORIG (issue originals) and DUP (issue duplicates).
REQ-016 SHALL transition ORIG->DUP at a non-stalled edge when (qed_exec_dup=1 and dup_count>0) or dup_count==DEPTH.
REQ-017 SHALL remain in DUP, regardless of qed_exec_dup, until the pop that makes dup_count 0, then return to ORIG on that edge.
REQ-018 SHALL drive inst_ready=1 only when state=ORIG, pipeline_stall=0, dup_count<DEPTH, and the ORIG->DUP condition is false.
REQ-019 SHALL, on inst_valid&inst_ready: register instruction unchanged to qed_ifu_instruction, qed_vld_out=1, qed_is_dup=0, and push its remapped copy into the queue.
REQ-020 SHALL, in DUP with pipeline_stall=0: pop queue head into qed_ifu_instruction, qed_vld_out=1, qed_is_dup=1; issue order equals original order (FIFO).
REQ-021 SHALL pulse qed_vld_out for exactly one cycle per issue, with latency 1 cycle from the accepting/popping edge; otherwise qed_vld_out=0.
REQ-022 SHALL, while pipeline_stall=1: no push, no pop, no state change, qed_ifu_instruction and qed_is_dup held, qed_vld_out=0.
REQ-023 SHALL remap by setting bit 4 of a nonzero register field (x0 stays x0): opcode 0110011 rd,rs1,rs2; 0010011 and 0000011 rd,rs1; 0100011 rs1,rs2; any other opcode copied unchanged.
REQ-024 SHALL leave funct3, funct7 and immediate bits unchanged by remap.
REQ-025 SHALL never push when dup_count==DEPTH nor pop when dup_count==0; pointers wrap modulo DEPTH.
REQ-026 SHALL keep dup_count = pushes - pops, push and pop never in the same cycle.

Reset
REQ-027 SHALL, on a clock edge with reset=0, set state=ORIG, queue empty, dup_count=0, qed_vld_out=0, qed_is_dup=0, qed_ifu_instruction=32'h00000013, regardless of stall or operation in progress.
REQ-028 SHALL drive inst_ready=0 and qed_ready=1 while reset=0.
REQ-029 SHALL discard all queued duplicates on reset mid-DUP; no stale entry issues after reset release.

Verification
REQ-030 SHALL verify: push 0x003100B3 (add x1,x2,x3), then qed_exec_dup=1 -> original 0x003100B3 issued qed_is_dup=0, next issue 0x013908B3 qed_is_dup=1, qed_ready=1 after.
REQ-031 SHALL verify: push 0x00000013 then dup -> duplicate 0x00000013 (x0 unremapped); push 0x0000006F (jal) -> duplicate unchanged.
REQ-032 SHALL verify: 8 consecutive valid originals, qed_exec_dup=0 -> dup_count=8, inst_ready=0, forced DUP issues 8 duplicates in order, then ORIG.
REQ-033 SHALL verify: pipeline_stall=1 for 3 cycles during DUP with dup_count=3 -> outputs held, qed_vld_out=0, dup_count stays 3, resumes in order.
REQ-034 SHALL verify: reset=0 asserted with dup_count=5 in DUP -> next cycle dup_count=0, state ORIG, qed_ifu_instruction=0x00000013, qed_vld_out=0.
REQ-035 SHALL verify: qed_exec_dup deasserted mid-DUP with dup_count=4 -> all 4 duplicates still issue before ORIG resumes.

Source files
------------

// File: rtl/qed_dup_scheduler.sv
// QED duplicate scheduler: issues fetched originals, queues a register-remapped
// copy of each, and later issues those copies in original order.
module qed_dup_scheduler #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic             qed_exec_dup,
    input  logic             pipeline_stall,
    output logic [31:0]      qed_ifu_instruction,
    output logic             qed_vld_out,
    output logic             qed_is_dup,
    output logic [CNT_W-1:0] dup_count,
    output logic             qed_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        ORIG = 1'b0,
        DUP  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      queue_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      issue_instr_reg;
    logic             issue_vld_reg;
    logic             issue_dup_reg;

    logic q_full, q_empty, go_dup, push, pop;

    // Duplicates use the upper half of the register file: bit 4 of every
    // nonzero register field is forced high; x0 must stay x0.
    function automatic logic [31:0] remap(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        case (x[6:0])
            7'b0110011: begin
                y[11] = x[11] | (|x[11:7]);
                y[19] = x[19] | (|x[19:15]);
                y[24] = x[24] | (|x[24:20]);
            end
            7'b0010011, 7'b0000011: begin
                y[11] = x[11] | (|x[11:7]);
                y[19] = x[19] | (|x[19:15]);
            end
            7'b0100011: begin
                y[19] = x[19] | (|x[19:15]);
                y[24] = x[24] | (|x[24:20]);
            end
            default: y = x;
        endcase
        return y;
    endfunction

    always_comb begin
        q_full     = (count_reg == DEPTH_CNT);
        q_empty    = (count_reg == '0);
        go_dup     = (qed_exec_dup && !q_empty) || q_full;
        inst_ready = reset && (state_reg == ORIG) && !pipeline_stall && !q_full && !go_dup;
        push       = inst_valid && inst_ready;
        pop        = reset && (state_reg == DUP) && !pipeline_stall && !q_empty;
    end

    always_comb begin
        state_next = state_reg;
        if (!pipeline_stall) begin
            case (state_reg)
                ORIG: if (go_dup) state_next = DUP;
                DUP:  if (q_empty || (pop && count_reg == CNT_W'(1))) state_next = ORIG;
                default: state_next = ORIG;
            endcase
        end
    end

    // Queue storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) queue_mem[wr_ptr_reg] <= remap(instruction);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= ORIG;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            issue_instr_reg <= NOP_INSTR;
            issue_vld_reg   <= 1'b0;
            issue_dup_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            issue_vld_reg <= push || pop;
            if (push) begin
                issue_instr_reg <= instruction;
                issue_dup_reg   <= 1'b0;
                wr_ptr_reg      <= wr_ptr_reg + PTR_W'(1);
                count_reg       <= count_reg + CNT_W'(1);
            end else if (pop) begin
                issue_instr_reg <= queue_mem[rd_ptr_reg];
                issue_dup_reg   <= 1'b1;
                rd_ptr_reg      <= rd_ptr_reg + PTR_W'(1);
                count_reg       <= count_reg - CNT_W'(1);
            end
        end
    end

    assign qed_ifu_instruction = issue_instr_reg;
    assign qed_vld_out         = issue_vld_reg;
    assign qed_is_dup          = issue_dup_reg;
    assign dup_count           = count_reg;
    assign qed_ready           = !reset || q_empty;

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Testbench for qed_dup_scheduler: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based behavioural model.
module tb_qed_dup_scheduler;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [31:0]      instruction = '0;
    logic             inst_valid = 1'b0;
    logic             inst_ready;
    logic             qed_exec_dup = 1'b0;
    logic             pipeline_stall = 1'b0;
    logic [31:0]      qed_ifu_instruction;
    logic             qed_vld_out;
    logic             qed_is_dup;
    logic [CNT_W-1:0] dup_count;
    logic             qed_ready;

    qed_dup_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .instruction         (instruction),
        .inst_valid          (inst_valid),
        .inst_ready          (inst_ready),
        .qed_exec_dup        (qed_exec_dup),
        .pipeline_stall      (pipeline_stall),
        .qed_ifu_instruction (qed_ifu_instruction),
        .qed_vld_out         (qed_vld_out),
        .qed_is_dup          (qed_is_dup),
        .dup_count           (dup_count),
        .qed_ready           (qed_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pending duplicates as a queue plus a "draining" flag.
    logic [31:0] mdl_q[$];
    bit          mdl_dup;
    logic [31:0] mdl_instr;
    bit          mdl_is_dup;
    bit          mdl_vld;
    bit          mdl_ready;
    bit          mdl_qready;
    logic        obs_ready;
    logic        obs_qready;

    function automatic logic [31:0] ref_remap(input logic [31:0] x);
        logic [31:0] y;
        bit use_f [3];
        int pos;
        y = x;
        use_f[0] = 0; use_f[1] = 0; use_f[2] = 0;   // rd, rs1, rs2
        case (x[6:0])
            7'h33:        begin use_f[0] = 1; use_f[1] = 1; use_f[2] = 1; end
            7'h13, 7'h03: begin use_f[0] = 1; use_f[1] = 1; end
            7'h23:        begin use_f[1] = 1; use_f[2] = 1; end
            default: ;
        endcase
        for (int k = 0; k < 3; k++) begin
            pos = (k == 0) ? 7 : (k == 1) ? 15 : 20;
            if (use_f[k] && (((x >> pos) & 32'h1F) != 0))
                y = y | (32'h10 << pos);
        end
        return y;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 5))
            0: x[6:0] = 7'h33;
            1: x[6:0] = 7'h13;
            2: x[6:0] = 7'h03;
            3: x[6:0] = 7'h23;
            4: x[6:0] = 7'h6F;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) x[11:7] = 5'd0;
        if ($urandom_range(0, 3) == 0) x[19:15] = 5'd0;
        if ($urandom_range(0, 3) == 0) x[24:20] = 5'd0;
        return x;
    endfunction

    task automatic model_edge(input bit v, input logic [31:0] ins, input bit ex,
                              input bit st, input bit rn);
        int n;
        bit go;
        n = mdl_q.size();
        if (!rn) begin
            mdl_ready  = 0;
            mdl_qready = 1;
            mdl_q.delete();
            mdl_dup    = 0;
            mdl_instr  = 32'h0000_0013;
            mdl_is_dup = 0;
            mdl_vld    = 0;
        end else begin
            mdl_qready = (n == 0);
            go         = (ex && n > 0) || (n == DEPTH);
            mdl_ready  = !mdl_dup && !st && (n < DEPTH) && !go;
            mdl_vld    = 0;
            if (!st) begin
                if (!mdl_dup) begin
                    if (go) mdl_dup = 1;
                    else if (v) begin
                        mdl_instr  = ins;
                        mdl_is_dup = 0;
                        mdl_vld    = 1;
                        mdl_q.push_back(ref_remap(ins));
                    end
                end else if (n > 0) begin
                    mdl_instr  = mdl_q.pop_front();
                    mdl_is_dup = 1;
                    mdl_vld    = 1;
                    if (mdl_q.size() == 0) mdl_dup = 0;
                end else begin
                    mdl_dup = 0;
                end
            end
        end
    endtask

    // One clock: drive at negedge, sample combinational outputs, then the edge.
    task automatic step(input bit v, input logic [31:0] ins, input bit ex,
                        input bit st, input bit rn);
        @(negedge clk);
        inst_valid     = v;
        instruction    = ins;
        qed_exec_dup   = ex;
        pipeline_stall = st;
        reset          = rn;
        #1;
        obs_ready  = inst_ready;
        obs_qready = qed_ready;
        model_edge(v, ins, ex, st, rn);
        @(posedge clk);
        #1;
        if (qed_vld_out === 1'b1)
            $display("issue t=%0t instr=%08h dup=%0b count=%0d", $time, qed_ifu_instruction,
                     qed_is_dup, dup_count);
    endtask

    task automatic test_reset();
        step(0, 32'h0, 0, 0, 0);
        step(1, 32'h003100B3, 1, 1, 0);
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL reset_inst_ready got %b want 0", obs_ready); end
        checks++; if (obs_qready !== 1'b1) begin errors++; $display("FAIL reset_qed_ready got %b want 1", obs_qready); end
        checks++; if (qed_ifu_instruction !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %08h want 00000013", qed_ifu_instruction); end
        checks++; if (qed_vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", qed_vld_out); end
        checks++; if (qed_is_dup !== 1'b0) begin errors++; $display("FAIL reset_is_dup got %b want 0", qed_is_dup); end
        checks++; if (dup_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", dup_count); end
        step(0, 32'h0, 0, 0, 1);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", obs_ready); end
    endtask

    task automatic test_add_dup();
        step(1, 32'h003100B3, 0, 0, 1);
        checks++; if (qed_vld_out !== 1'b1 || qed_ifu_instruction !== 32'h003100B3 || qed_is_dup !== 1'b0)
            begin errors++; $display("FAIL add_orig got vld=%b instr=%08h dup=%b want 1/003100b3/0", qed_vld_out, qed_ifu_instruction, qed_is_dup); end
        checks++; if (dup_count !== 4'd1) begin errors++; $display("FAIL add_count got %0d want 1", dup_count); end
        step(0, 32'h0, 1, 0, 1);
        checks++; if (qed_vld_out !== 1'b0) begin errors++; $display("FAIL add_switch_vld got %b want 0", qed_vld_out); end
        step(0, 32'h0, 1, 0, 1);
        checks++; if (qed_vld_out !== 1'b1 || qed_ifu_instruction !== 32'h013908B3 || qed_is_dup !== 1'b1)
            begin errors++; $display("FAIL add_dup got vld=%b instr=%08h dup=%b want 1/013908b3/1", qed_vld_out, qed_ifu_instruction, qed_is_dup); end
        checks++; if (qed_ready !== 1'b1) begin errors++; $display("FAIL add_qed_ready got %b want 1", qed_ready); end
        step(0, 32'h0, 0, 0, 1);
        checks++; if (qed_vld_out !== 1'b0 || obs_ready !== 1'b1)
            begin errors++; $display("FAIL add_back_orig got vld=%b ready=%b want 0/1", qed_vld_out, obs_ready); end
    endtask

    task automatic test_x0_jal();
        logic [31:0] ins [2];
        ins[0] = 32'h0000_0013;
        ins[1] = 32'h0000_006F;
        for (int i = 0; i < 2; i++) begin
            step(1, ins[i], 0, 0, 1);
            step(0, 32'h0, 1, 0, 1);
            step(0, 32'h0, 0, 0, 1);
            checks++; if (qed_vld_out !== 1'b1 || qed_is_dup !== 1'b1 || qed_ifu_instruction !== ins[i])
                begin errors++; $display("FAIL x0_jal_dup%0d got vld=%b dup=%b instr=%08h want 1/1/%08h", i, qed_vld_out, qed_is_dup, qed_ifu_instruction, ins[i]); end
        end
    endtask

    task automatic test_fill();
        logic [31:0] saved [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            saved[i] = rand_instr();
            step(1, saved[i], 0, 0, 1);
        end
        checks++; if (dup_count !== CNT_W'(DEPTH)) begin errors++; $display("FAIL fill_count got %0d want %0d", dup_count, DEPTH); end
        checks++; if (qed_ready !== 1'b0) begin errors++; $display("FAIL fill_qed_ready got %b want 0", qed_ready); end
        step(1, rand_instr(), 0, 0, 1);
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", obs_ready); end
        checks++; if (qed_vld_out !== 1'b0 || dup_count !== CNT_W'(DEPTH))
            begin errors++; $display("FAIL fill_switch got vld=%b count=%0d want 0/%0d", qed_vld_out, dup_count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 32'h0, 0, 0, 1);
            checks++; if (qed_vld_out !== 1'b1 || qed_is_dup !== 1'b1 || qed_ifu_instruction !== ref_remap(saved[i]))
                begin errors++; $display("FAIL fill_dup%0d got vld=%b dup=%b instr=%08h want 1/1/%08h", i, qed_vld_out, qed_is_dup, qed_ifu_instruction, ref_remap(saved[i])); end
        end
        step(0, 32'h0, 0, 0, 1);
        checks++; if (obs_ready !== 1'b1 || qed_vld_out !== 1'b0)
            begin errors++; $display("FAIL fill_back_orig got ready=%b vld=%b want 1/0", obs_ready, qed_vld_out); end
    endtask

    task automatic test_stall();
        logic [31:0] saved [3];
        logic [31:0] held;
        for (int i = 0; i < 3; i++) begin
            saved[i] = rand_instr();
            step(1, saved[i], 0, 0, 1);
        end
        step(0, 32'h0, 1, 0, 1);
        held = saved[2];
        for (int i = 0; i < 3; i++) begin
            step(1, rand_instr(), 1'($urandom_range(0, 1)), 1, 1);
            checks++; if (qed_vld_out !== 1'b0 || qed_ifu_instruction !== held || qed_is_dup !== 1'b0 || dup_count !== 4'd3)
                begin errors++; $display("FAIL stall_hold%0d got vld=%b instr=%08h dup=%b count=%0d want 0/%08h/0/3", i, qed_vld_out, qed_ifu_instruction, qed_is_dup, dup_count, held); end
            checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got %b want 0", i, obs_ready); end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 0, 0, 1);
            checks++; if (qed_vld_out !== 1'b1 || qed_is_dup !== 1'b1 || qed_ifu_instruction !== ref_remap(saved[i]))
                begin errors++; $display("FAIL stall_resume%0d got vld=%b dup=%b instr=%08h want 1/1/%08h", i, qed_vld_out, qed_is_dup, qed_ifu_instruction, ref_remap(saved[i])); end
        end
    endtask

    task automatic test_reset_mid_dup();
        for (int i = 0; i < 6; i++) step(1, rand_instr(), 0, 0, 1);
        step(0, 32'h0, 1, 0, 1);
        step(0, 32'h0, 1, 0, 1);
        checks++; if (dup_count !== 4'd5 || qed_is_dup !== 1'b1)
            begin errors++; $display("FAIL midrst_setup got count=%0d dup=%b want 5/1", dup_count, qed_is_dup); end
        step(0, 32'h0, 1, 1, 0);
        checks++; if (dup_count !== 4'd0 || qed_ifu_instruction !== 32'h0000_0013 || qed_vld_out !== 1'b0 || qed_is_dup !== 1'b0)
            begin errors++; $display("FAIL midrst_clear got count=%0d instr=%08h vld=%b dup=%b want 0/00000013/0/0", dup_count, qed_ifu_instruction, qed_vld_out, qed_is_dup); end
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 1, 0, 1);
            checks++; if (qed_vld_out !== 1'b0 || obs_ready !== 1'b1)
                begin errors++; $display("FAIL midrst_stale%0d got vld=%b ready=%b want 0/1", i, qed_vld_out, obs_ready); end
        end
    endtask

    task automatic test_exec_drop();
        logic [31:0] saved [4];
        for (int i = 0; i < 4; i++) begin
            saved[i] = rand_instr();
            step(1, saved[i], 0, 0, 1);
        end
        step(0, 32'h0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, rand_instr(), 0, 0, 1);
            checks++; if (qed_vld_out !== 1'b1 || qed_is_dup !== 1'b1 || qed_ifu_instruction !== ref_remap(saved[i]))
                begin errors++; $display("FAIL drop_dup%0d got vld=%b dup=%b instr=%08h want 1/1/%08h", i, qed_vld_out, qed_is_dup, qed_ifu_instruction, ref_remap(saved[i])); end
        end
        step(0, 32'h0, 0, 0, 1);
        checks++; if (obs_ready !== 1'b1 || dup_count !== 4'd0)
            begin errors++; $display("FAIL drop_back_orig got ready=%b count=%0d want 1/0", obs_ready, dup_count); end
    endtask

    task automatic test_random();
        bit v, ex, st, rn;
        for (int c = 0; c < 500; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            ex = ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 4) == 0);
            rn = ($urandom_range(0, 60) != 0);
            step(v, rand_instr(), ex, st, rn);
            checks++; if (obs_ready !== mdl_ready || obs_qready !== mdl_qready)
                begin errors++; $display("FAIL rand_comb c=%0d got ready=%b qready=%b want %b/%b", c, obs_ready, obs_qready, mdl_ready, mdl_qready); end
            checks++; if (qed_vld_out !== mdl_vld || qed_is_dup !== mdl_is_dup || qed_ifu_instruction !== mdl_instr)
                begin errors++; $display("FAIL rand_issue c=%0d got vld=%b dup=%b instr=%08h want %b/%b/%08h", c, qed_vld_out, qed_is_dup, qed_ifu_instruction, mdl_vld, mdl_is_dup, mdl_instr); end
            checks++; if (dup_count !== CNT_W'(mdl_q.size()))
                begin errors++; $display("FAIL rand_count c=%0d got %0d want %0d", c, dup_count, mdl_q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_add_dup();
        test_x0_jal();
        test_fill();
        test_stall();
        test_reset_mid_dup();
        test_exec_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
